random_stream_cmd: RTL and testbench

Host-command decoder for the random-byte stream. It consumes bytes delivered by the UART receiver and turns them into stream control:
- soft reset;
- stop;
- continuous streaming;
- fixed-length bursts.

It gates the start strobe that hands LFSR bytes to the UART transmitter, and sits between the `uart` instance and `randomized_lfsr` in the top level.

---
 rtl/random_stream_cmd.sv | 157 +++++++++++++++
 tb/tb_random_stream_cmd.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/random_stream_cmd.sv
// Host-command decoder for the random-byte stream: 'r' soft reset, 's' stop, 'c' continuous, 'b' <hi> <lo> burst.
// Optional inter-byte timeout is compiled in when RANDOM_STREAM_CMD_TIMEOUT_EN is defined.
module random_stream_cmd #(
  parameter int CLOCKFRQ   = 12000000,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_error,
  input  logic        word_ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic        soft_reset,
  output logic [1:0]  mode,
  output logic [15:0] burst_left,
  output logic        cmd_error,
  output logic        parsing
);

  localparam int TIMEOUT_CYCLES = CLOCKFRQ / 1000000 * TIMEOUT_US;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("random_stream_cmd: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [1:0] M_STOP  = 2'd0;
  localparam logic [1:0] M_CONT  = 2'd1;
  localparam logic [1:0] M_BURST = 2'd2;

  localparam logic [7:0] CH_R = 8'h72;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_C = 8'h63;
  localparam logic [7:0] CH_B = 8'h62;

  typedef enum logic [1:0] {P_IDLE, P_HI, P_LO} pstate_e;

  pstate_e     state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] burst_left_q, burst_left_d;
  logic [7:0]  cnt_hi_q, cnt_hi_d;
  logic        soft_reset_q, soft_reset_d;
  logic        cmd_error_q, cmd_error_d;
  logic        timeout_hit;

  assign parsing    = (state_q != P_IDLE);
  assign mode       = mode_q;
  assign burst_left = burst_left_q;
  assign soft_reset = soft_reset_q;
  assign cmd_error  = cmd_error_q;

  assign tx_start = word_ready & ~tx_busy &
                    ((mode_q == M_CONT) | ((mode_q == M_BURST) & (burst_left_q != 16'd0)));

`ifdef RANDOM_STREAM_CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (rx_valid || !parsing) tmo_cnt_d = '0;
    else                      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end

  // Fires on the edge that completes TIMEOUT_CYCLES idle cycles since the last byte.
  assign timeout_hit = parsing && !rx_valid && !rx_error &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    burst_left_d = burst_left_q;
    cnt_hi_d     = cnt_hi_q;
    soft_reset_d = 1'b0;
    cmd_error_d  = 1'b0;

    // Burst bookkeeping first so a completing command below overrides it.
    if (mode_q == M_BURST) begin
      if (tx_start)                      burst_left_d = burst_left_q - 16'd1;
      else if (burst_left_q == 16'd0)    mode_d       = M_STOP;
    end

    if (rx_error) begin
      cmd_error_d = 1'b1;
      state_d     = P_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        P_IDLE: begin
          case (rx_byte)
            CH_R: begin
              soft_reset_d = 1'b1;
              mode_d       = M_CONT;
              burst_left_d = 16'd0;
            end
            CH_S: begin
              mode_d       = M_STOP;
              burst_left_d = 16'd0;
            end
            CH_C: begin
              mode_d       = M_CONT;
              burst_left_d = 16'd0;
            end
            CH_B:    state_d     = P_HI;
            default: cmd_error_d = 1'b1;
          endcase
        end
        P_HI: begin
          cnt_hi_d = rx_byte;
          state_d  = P_LO;
        end
        P_LO: begin
          state_d = P_IDLE;
          if ({cnt_hi_q, rx_byte} != 16'd0) begin
            mode_d       = M_BURST;
            burst_left_d = {cnt_hi_q, rx_byte};
          end else begin
            mode_d       = M_STOP;
            burst_left_d = 16'd0;
          end
        end
        default: state_d = P_IDLE;
      endcase
    end else if (timeout_hit) begin
      cmd_error_d = 1'b1;
      state_d     = P_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= P_IDLE;
      mode_q       <= M_CONT;
      burst_left_q <= 16'd0;
      cnt_hi_q     <= 8'd0;
      soft_reset_q <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      burst_left_q <= burst_left_d;
      cnt_hi_q     <= cnt_hi_d;
      soft_reset_q <= soft_reset_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

endmodule

// File: tb/tb_random_stream_cmd.sv
// Table-driven bench for random_stream_cmd, plus async-reset and inter-byte timeout sequences.
module tb_random_stream_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_error;
  logic        word_ready;
  logic        tx_busy;
  logic        tx_start;
  logic        soft_reset;
  logic [1:0]  mode;
  logic [15:0] burst_left;
  logic        cmd_error;
  logic        parsing;

  always #5 clk = ~clk;

  random_stream_cmd #(.CLOCKFRQ(1000000), .TIMEOUT_US(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error),
    .word_ready (word_ready),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .soft_reset (soft_reset),
    .mode       (mode),
    .burst_left (burst_left),
    .cmd_error  (cmd_error),
    .parsing    (parsing)
  );

  typedef struct {
    logic        rv;
    logic [7:0]  rb;
    logic        re;
    logic        wr;
    logic        tb;
    logic        ts;
    logic [1:0]  md;
    logic [15:0] bl;
    logic        sr;
    logic        ce;
    logic        pa;
  } vec_t;

  vec_t vt[$];
  int   n_vec  = 0;
  int   n_chk  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic av(input logic rv, input logic [7:0] rb, input logic re, input logic wr,
                    input logic tb, input logic ts, input logic [1:0] md, input logic [15:0] bl,
                    input logic sr, input logic ce, input logic pa);
    vec_t v;
    v.rv = rv; v.rb = rb; v.re = re; v.wr = wr; v.tb = tb;
    v.ts = ts; v.md = md; v.bl = bl; v.sr = sr; v.ce = ce; v.pa = pa;
    vt.push_back(v);
  endtask

  task automatic check_regs(input string tag, input logic [1:0] md, input logic [15:0] bl,
                            input logic sr, input logic ce, input logic pa);
    chk({tag, ".mode"},       16'(mode),       16'(md));
    chk({tag, ".burst_left"}, burst_left,      bl);
    chk({tag, ".soft_reset"}, 16'(soft_reset), 16'(sr));
    chk({tag, ".cmd_error"},  16'(cmd_error),  16'(ce));
    chk({tag, ".parsing"},    16'(parsing),    16'(pa));
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rx_valid   = v.rv;
    rx_byte    = v.rb;
    rx_error   = v.re;
    word_ready = v.wr;
    tx_busy    = v.tb;
    #1;
    chk({tag, ".tx_start"}, 16'(tx_start), 16'(v.ts));
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    check_regs(tag, v.md, v.bl, v.sr, v.ce, v.pa);
    n_vec++;
  endtask

  task automatic send(input logic [7:0] b, input string tag, input logic [1:0] md,
                      input logic [15:0] bl, input logic pa);
    vec_t v;
    v.rv = 1'b1; v.rb = b; v.re = 1'b0; v.wr = 1'b0; v.tb = 1'b0;
    v.ts = 1'b0; v.md = md; v.bl = bl; v.sr = 1'b0; v.ce = 1'b0; v.pa = pa;
    apply(v, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] S = 2'd0, C = 2'd1, B = 2'd2;

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; rx_error = 1'b0;
    word_ready = 1'b1; tx_busy = 1'b0;

    //   rv  rb     re  wr  tb  ts  md  bl        sr  ce  pa
    av(0, 8'h00, 0, 1, 0, 1, C, 16'h0000, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 1, C, 16'h0000, 0, 0, 0);
    av(0, 8'h00, 0, 1, 1, 0, C, 16'h0000, 0, 0, 0);
    av(1, 8'h73, 0, 0, 0, 0, S, 16'h0000, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 0, S, 16'h0000, 0, 0, 0);
    av(1, 8'h62, 0, 0, 0, 0, S, 16'h0000, 0, 0, 1);
    av(1, 8'h00, 0, 0, 0, 0, S, 16'h0000, 0, 0, 1);
    av(1, 8'h03, 0, 0, 0, 0, B, 16'h0003, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 1, B, 16'h0002, 0, 0, 0);
    av(0, 8'h00, 0, 0, 0, 0, B, 16'h0002, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 1, B, 16'h0001, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 1, B, 16'h0000, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 0, S, 16'h0000, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 0, S, 16'h0000, 0, 0, 0);
    av(0, 8'h00, 0, 0, 0, 0, S, 16'h0000, 0, 0, 0);
    av(1, 8'h62, 0, 0, 0, 0, S, 16'h0000, 0, 0, 1);
    av(1, 8'h72, 0, 0, 0, 0, S, 16'h0000, 0, 0, 1);
    av(1, 8'h10, 0, 0, 0, 0, B, 16'h7210, 0, 0, 0);
    av(1, 8'h78, 0, 0, 0, 0, B, 16'h7210, 0, 1, 0);
    av(0, 8'h00, 0, 0, 0, 0, B, 16'h7210, 0, 0, 0);
    av(1, 8'h63, 0, 1, 0, 1, C, 16'h0000, 0, 0, 0);
    av(1, 8'h62, 0, 0, 0, 0, C, 16'h0000, 0, 0, 1);
    av(1, 8'h01, 0, 0, 0, 0, C, 16'h0000, 0, 0, 1);
    av(1, 8'h72, 1, 0, 0, 0, C, 16'h0000, 0, 1, 0);
    av(0, 8'h00, 0, 0, 0, 0, C, 16'h0000, 0, 0, 0);
    av(1, 8'h72, 0, 0, 0, 0, C, 16'h0000, 1, 0, 0);
    av(0, 8'h00, 0, 0, 0, 0, C, 16'h0000, 0, 0, 0);
    av(1, 8'h73, 0, 0, 0, 0, S, 16'h0000, 0, 0, 0);
    av(1, 8'h63, 0, 0, 0, 0, C, 16'h0000, 0, 0, 0);
    av(1, 8'h62, 0, 0, 0, 0, C, 16'h0000, 0, 0, 1);
    av(1, 8'h00, 0, 0, 0, 0, C, 16'h0000, 0, 0, 1);
    av(1, 8'h00, 0, 0, 0, 0, S, 16'h0000, 0, 0, 0);
    av(0, 8'h00, 1, 0, 0, 0, S, 16'h0000, 0, 1, 0);
    av(1, 8'h62, 0, 0, 0, 0, S, 16'h0000, 0, 0, 1);
    av(1, 8'hFF, 0, 0, 0, 0, S, 16'h0000, 0, 0, 1);
    av(1, 8'hFF, 0, 0, 0, 0, B, 16'hFFFF, 0, 0, 0);
    av(0, 8'h00, 0, 1, 1, 0, B, 16'hFFFF, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 1, B, 16'hFFFE, 0, 0, 0);
    av(1, 8'h62, 0, 1, 0, 1, B, 16'hFFFD, 0, 0, 1);
    av(1, 8'h00, 0, 1, 0, 1, B, 16'hFFFC, 0, 0, 1);
    av(1, 8'h02, 0, 1, 0, 1, B, 16'h0002, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 1, B, 16'h0001, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 1, B, 16'h0000, 0, 0, 0);
    av(0, 8'h00, 0, 1, 0, 0, S, 16'h0000, 0, 0, 0);

    // Reset state, sampled while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset", C, 16'h0000, 0, 0, 0);
    chk("reset.tx_start", 16'(tx_start), 16'd1);
    n_vec++;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) apply(vt[i], $sformatf("v%0d", i));

    // Asynchronous reset mid-burst and mid-command.
    send(8'h62, "ar0", S, 16'h0000, 1);
    send(8'h00, "ar1", S, 16'h0000, 1);
    send(8'h05, "ar2", B, 16'h0005, 0);
    send(8'h62, "ar3", B, 16'h0005, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("async_rst", C, 16'h0000, 0, 0, 0);
    n_vec++;
    @(negedge clk);
    rst_n = 1'b1;

    // Inter-byte timeout after a lone 'b'.
    send(8'h62, "to0", C, 16'h0000, 1);
`ifdef RANDOM_STREAM_CMD_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k < 10) check_regs($sformatf("to_wait%0d", k), C, 16'h0000, 0, 0, 1);
      else        check_regs("to_fire", C, 16'h0000, 0, 1, 0);
      n_vec++;
    end
    @(posedge clk);
    #1;
    check_regs("to_after", C, 16'h0000, 0, 0, 0);
    n_vec++;
`else
    begin
      int bad_pa;
      int bad_ce;
      bad_pa = 0;
      bad_ce = 0;
      for (int k = 1; k <= 1000; k++) begin
        @(posedge clk);
        #1;
        if (parsing !== 1'b1)   bad_pa++;
        if (cmd_error !== 1'b0) bad_ce++;
      end
      chk("no_timeout.parsing_drops",   16'(bad_pa), 16'd0);
      chk("no_timeout.cmd_error_count", 16'(bad_ce), 16'd0);
      n_vec++;
    end
    begin
      vec_t v;
      v.rv = 1'b0; v.rb = 8'h00; v.re = 1'b1; v.wr = 1'b0; v.tb = 1'b0;
      v.ts = 1'b0; v.md = C; v.bl = 16'h0000; v.sr = 1'b0; v.ce = 1'b1; v.pa = 1'b0;
      apply(v, "no_timeout_abort");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
